// File: rtl/bp_pkg.sv
// Shared types, counter encodings and geometry helpers for the branch predictor.
// The BTB entry struct is sized for the default geometry used throughout the core.
package bp_pkg;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  function automatic int idx_w(input int entries);
    return $clog2(entries);
  endfunction

  // Word-aligned PCs: bits [1:0] are never part of the index or the tag.
  function automatic int tag_w(input int width, input int entries);
    return width - idx_w(entries) - 2;
  endfunction

  localparam int BP_WIDTH   = 32;
  localparam int BP_ENTRIES = 16;
  localparam int BP_TAGW    = tag_w(BP_WIDTH, BP_ENTRIES);

  typedef struct packed {
    logic                valid;
    logic [BP_TAGW-1:0]  tag;
    logic [BP_WIDTH-1:0] target;
    logic [1:0]          ctr;
  } btb_entry_t;

endpackage

// File: rtl/bp_sat_ctr2.sv
// Combinational 2-bit saturating counter step: up increments toward 11,
// otherwise decrements toward 00.
module bp_sat_ctr2
  import bp_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       up,
  output logic [1:0] ctr_next
);

  always_comb begin
    ctr_next = ctr;
    if (up) begin
      if (ctr != CTR_ST) ctr_next = ctr + 2'd1;
    end else begin
      if (ctr != CTR_SNT) ctr_next = ctr - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit counters driving the fetch redirect, plus the
// execute-stage mispredict redirect and saturating performance counters.
module branch_predictor
  import bp_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int ENTRIES = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic [WIDTH-1:0] fetch_pc,
  output logic             branchpredict,
  output logic [WIDTH-1:0] pcbranch,
  input  logic             ex_branch,
  input  logic [WIDTH-1:0] ex_pc,
  input  logic             ex_taken,
  input  logic [WIDTH-1:0] ex_target,
  input  logic             ex_pred_taken,
  input  logic [WIDTH-1:0] ex_pred_target,
  output logic             valid,
  output logic [WIDTH-1:0] pcbranch2,
  output logic [31:0]      branch_count,
  output logic [31:0]      mispredict_count
);

  localparam int IDXW = idx_w(ENTRIES);
  localparam int TAGW = tag_w(WIDTH, ENTRIES);

  // The entry struct lives in the package at a fixed geometry, so the
  // instance parameters must agree with it.
  if (WIDTH != BP_WIDTH || ENTRIES != BP_ENTRIES || ENTRIES < 2 ||
      (ENTRIES & (ENTRIES - 1)) != 0) begin : g_bad_geometry
    $error("branch_predictor: unsupported WIDTH/ENTRIES");
  end

  btb_entry_t btb_q [ENTRIES];

  logic [IDXW-1:0] f_idx, e_idx;
  logic [TAGW-1:0] f_tag, e_tag;
  btb_entry_t      f_ent, e_ent;
  logic            f_hit, e_hit;
  logic [1:0]      ctr_next;
  logic            upd;
  logic            unused_fetch_lsbs;

  assign f_idx = fetch_pc[IDXW+1:2];
  assign f_tag = fetch_pc[WIDTH-1:IDXW+2];
  assign e_idx = ex_pc[IDXW+1:2];
  assign e_tag = ex_pc[WIDTH-1:IDXW+2];
  assign unused_fetch_lsbs = ^fetch_pc[1:0];

  assign f_ent = btb_q[f_idx];
  assign e_ent = btb_q[e_idx];
  assign f_hit = f_ent.valid && (f_ent.tag == f_tag);
  assign e_hit = e_ent.valid && (e_ent.tag == e_tag);

  // Mispredict recovery outranks prediction because the PC register
  // gives branchpredict priority.
  assign valid = ex_branch && ((ex_taken != ex_pred_taken) ||
                               (ex_taken && (ex_pred_target != ex_target)));
  assign pcbranch2     = ex_taken ? ex_target : ex_pc + WIDTH'(4);
  assign branchpredict = f_hit && f_ent.ctr[1] && !valid;
  assign pcbranch      = f_ent.target;

  assign upd = ex_branch && !stall;

  bp_sat_ctr2 u_ctr (
    .ctr      (e_ent.ctr),
    .up       (ex_taken),
    .ctr_next (ctr_next)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        btb_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_WNT};
      end
    end else if (upd) begin
      if (ex_taken) begin
        if (e_hit) begin
          btb_q[e_idx].ctr    <= ctr_next;
          btb_q[e_idx].target <= ex_target;
        end else begin
          btb_q[e_idx] <= '{valid: 1'b1, tag: e_tag, target: ex_target, ctr: CTR_WT};
        end
      end else if (e_hit) begin
        btb_q[e_idx].ctr <= ctr_next;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      branch_count     <= '0;
      mispredict_count <= '0;
    end else if (upd) begin
      if (branch_count != 32'hFFFF_FFFF) branch_count <= branch_count + 32'd1;
      if (valid && mispredict_count != 32'hFFFF_FFFF)
        mispredict_count <= mispredict_count + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: training, aliasing, stall, same-cycle
// lookup/update ordering, mispredict redirect and async reset.
module tb_branch_predictor;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         stall;
  logic [W-1:0] fetch_pc;
  logic         branchpredict;
  logic [W-1:0] pcbranch;
  logic         ex_branch;
  logic [W-1:0] ex_pc;
  logic         ex_taken;
  logic [W-1:0] ex_target;
  logic         ex_pred_taken;
  logic [W-1:0] ex_pred_target;
  logic         valid;
  logic [W-1:0] pcbranch2;
  logic [31:0]  branch_count;
  logic [31:0]  mispredict_count;

  int n_checks = 0;
  int n_fail   = 0;

  branch_predictor #(.WIDTH(W), .ENTRIES(16)) dut (
    .clk              (clk),
    .reset            (reset),
    .stall            (stall),
    .fetch_pc         (fetch_pc),
    .branchpredict    (branchpredict),
    .pcbranch         (pcbranch),
    .ex_branch        (ex_branch),
    .ex_pc            (ex_pc),
    .ex_taken         (ex_taken),
    .ex_target        (ex_target),
    .ex_pred_taken    (ex_pred_taken),
    .ex_pred_target   (ex_pred_target),
    .valid            (valid),
    .pcbranch2        (pcbranch2),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ex(input logic [W-1:0] pc, input logic tk, input logic [W-1:0] tgt,
                          input logic pt, input logic [W-1:0] ptgt);
    ex_branch = 1'b1; ex_pc = pc; ex_taken = tk; ex_target = tgt;
    ex_pred_taken = pt; ex_pred_target = ptgt;
  endtask

  task automatic clear_ex();
    ex_branch = 1'b0; ex_pc = '0; ex_taken = 1'b0; ex_target = '0;
    ex_pred_taken = 1'b0; ex_pred_target = '0;
  endtask

  // Apply one resolve through an unstalled edge, then go idle.
  task automatic resolve(input logic [W-1:0] pc, input logic tk, input logic [W-1:0] tgt,
                         input logic pt, input logic [W-1:0] ptgt);
    drive_ex(pc, tk, tgt, pt, ptgt);
    tick();
    clear_ex();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; stall = 1'b0; fetch_pc = 32'h100; clear_ex();
    tick(); tick();
    n_checks++; if (branchpredict !== 1'b0) begin n_fail++; $display("FAIL reset_bp: got %0b want 0", branchpredict); end
    n_checks++; if (pcbranch !== 32'h0) begin n_fail++; $display("FAIL reset_pcbranch: got %0h want 0", pcbranch); end
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", valid); end
    n_checks++; if (branch_count !== 32'd0) begin n_fail++; $display("FAIL reset_bcount: got %0d want 0", branch_count); end
    n_checks++; if (mispredict_count !== 32'd0) begin n_fail++; $display("FAIL reset_mcount: got %0d want 0", mispredict_count); end
    reset = 1'b0;
    tick();
    n_checks++; if (branchpredict !== 1'b0) begin n_fail++; $display("FAIL idle_bp: got %0b want 0", branchpredict); end
    n_checks++; if (branch_count !== 32'd0) begin n_fail++; $display("FAIL idle_bcount: got %0d want 0", branch_count); end
  endtask

  task automatic test_train_taken();
    fetch_pc = 32'h100;
    drive_ex(32'h100, 1'b1, 32'h200, 1'b0, 32'h0);
    #1;
    n_checks++; if (valid !== 1'b1) begin n_fail++; $display("FAIL train_valid: got %0b want 1", valid); end
    n_checks++; if (pcbranch2 !== 32'h200) begin n_fail++; $display("FAIL train_pc2: got %0h want 200", pcbranch2); end
    n_checks++; if (branchpredict !== 1'b0) begin n_fail++; $display("FAIL train_premiss_bp: got %0b want 0", branchpredict); end
    tick();
    clear_ex();
    #1;
    n_checks++; if (branchpredict !== 1'b1) begin n_fail++; $display("FAIL train_bp: got %0b want 1", branchpredict); end
    n_checks++; if (pcbranch !== 32'h200) begin n_fail++; $display("FAIL train_pcbranch: got %0h want 200", pcbranch); end
    n_checks++; if (mispredict_count !== 32'd1) begin n_fail++; $display("FAIL train_mcount: got %0d want 1", mispredict_count); end
    n_checks++; if (branch_count !== 32'd1) begin n_fail++; $display("FAIL train_bcount: got %0d want 1", branch_count); end
  endtask

  // Hit with counter 10 while the same-cycle resolve mispredicts: prediction suppressed.
  task automatic test_not_taken();
    fetch_pc = 32'h100;
    drive_ex(32'h100, 1'b0, 32'h0, 1'b1, 32'h200);
    #1;
    n_checks++; if (valid !== 1'b1) begin n_fail++; $display("FAIL nt_valid: got %0b want 1", valid); end
    n_checks++; if (pcbranch2 !== 32'h104) begin n_fail++; $display("FAIL nt_pc2: got %0h want 104", pcbranch2); end
    n_checks++; if (branchpredict !== 1'b0) begin n_fail++; $display("FAIL nt_suppress_bp: got %0b want 0", branchpredict); end
    tick();
    clear_ex();
    #1;
    n_checks++; if (branchpredict !== 1'b0) begin n_fail++; $display("FAIL nt_bp_after: got %0b want 0", branchpredict); end
    n_checks++; if (mispredict_count !== 32'd2) begin n_fail++; $display("FAIL nt_mcount: got %0d want 2", mispredict_count); end
  endtask

  task automatic test_alias_saturate();
    resolve(32'h100, 1'b1, 32'h200, 1'b0, 32'h0);    // 01 -> 10
    resolve(32'h100, 1'b1, 32'h200, 1'b1, 32'h200);  // 10 -> 11
    resolve(32'h100, 1'b1, 32'h200, 1'b1, 32'h200);  // stays 11
    fetch_pc = 32'h140;
    #1;
    n_checks++; if (branchpredict !== 1'b0) begin n_fail++; $display("FAIL alias_bp: got %0b want 0", branchpredict); end
    fetch_pc = 32'h100;
    #1;
    n_checks++; if (branchpredict !== 1'b1) begin n_fail++; $display("FAIL trained_bp: got %0b want 1", branchpredict); end
    resolve(32'h100, 1'b0, 32'h0, 1'b1, 32'h200);    // 11 -> 10
    n_checks++; if (branchpredict !== 1'b1) begin n_fail++; $display("FAIL sat_nt1_bp: got %0b want 1", branchpredict); end
    resolve(32'h100, 1'b0, 32'h0, 1'b1, 32'h200);    // 10 -> 01
    n_checks++; if (branchpredict !== 1'b0) begin n_fail++; $display("FAIL sat_nt2_bp: got %0b want 0", branchpredict); end
    n_checks++; if (branch_count !== 32'd7) begin n_fail++; $display("FAIL alias_bcount: got %0d want 7", branch_count); end
    n_checks++; if (mispredict_count !== 32'd5) begin n_fail++; $display("FAIL alias_mcount: got %0d want 5", mispredict_count); end
  endtask

  task automatic test_target_and_wrap();
    fetch_pc = 32'h100;
    drive_ex(32'h100, 1'b1, 32'h300, 1'b1, 32'h200);
    #1;
    n_checks++; if (valid !== 1'b1) begin n_fail++; $display("FAIL tgt_valid: got %0b want 1", valid); end
    n_checks++; if (pcbranch2 !== 32'h300) begin n_fail++; $display("FAIL tgt_pc2: got %0h want 300", pcbranch2); end
    tick();
    clear_ex();
    #1;
    n_checks++; if (branchpredict !== 1'b1) begin n_fail++; $display("FAIL tgt_bp: got %0b want 1", branchpredict); end
    n_checks++; if (pcbranch !== 32'h300) begin n_fail++; $display("FAIL tgt_pcbranch: got %0h want 300", pcbranch); end
    drive_ex(32'hFFFF_FFFC, 1'b0, 32'h0, 1'b1, 32'h0);
    #1;
    n_checks++; if (pcbranch2 !== 32'h0) begin n_fail++; $display("FAIL wrap_pc2: got %0h want 0", pcbranch2); end
    n_checks++; if (valid !== 1'b1) begin n_fail++; $display("FAIL wrap_valid: got %0b want 1", valid); end
    tick();
    clear_ex();
    #1;
    n_checks++; if (branch_count !== 32'd9) begin n_fail++; $display("FAIL wrap_bcount: got %0d want 9", branch_count); end
  endtask

  task automatic test_stall();
    resolve(32'h100, 1'b0, 32'h0, 1'b1, 32'h300);    // 10 -> 01
    drive_ex(32'h100, 1'b1, 32'h300, 1'b1, 32'h300);
    stall = 1'b1;
    tick(); tick(); tick();
    n_checks++; if (branch_count !== 32'd10) begin n_fail++; $display("FAIL stall_hold_bcount: got %0d want 10", branch_count); end
    n_checks++; if (branchpredict !== 1'b0) begin n_fail++; $display("FAIL stall_hold_bp: got %0b want 0", branchpredict); end
    stall = 1'b0;
    tick();
    clear_ex();
    #1;
    n_checks++; if (branch_count !== 32'd11) begin n_fail++; $display("FAIL stall_bcount: got %0d want 11", branch_count); end
    n_checks++; if (mispredict_count !== 32'd8) begin n_fail++; $display("FAIL stall_mcount: got %0d want 8", mispredict_count); end
    resolve(32'h100, 1'b0, 32'h0, 1'b1, 32'h300);    // one step only: 10 -> 01
    n_checks++; if (branchpredict !== 1'b0) begin n_fail++; $display("FAIL stall_step_bp: got %0b want 0", branchpredict); end
  endtask

  task automatic test_back_to_back();
    fetch_pc = 32'h100;
    drive_ex(32'h100, 1'b1, 32'h300, 1'b1, 32'h300);
    #1;
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL b2b_valid: got %0b want 0", valid); end
    n_checks++; if (branchpredict !== 1'b0) begin n_fail++; $display("FAIL b2b_preupdate_bp: got %0b want 0", branchpredict); end
    tick();
    clear_ex();
    #1;
    n_checks++; if (branchpredict !== 1'b1) begin n_fail++; $display("FAIL b2b_postupdate_bp: got %0b want 1", branchpredict); end
    n_checks++; if (branch_count !== 32'd13) begin n_fail++; $display("FAIL b2b_bcount: got %0d want 13", branch_count); end
    n_checks++; if (mispredict_count !== 32'd9) begin n_fail++; $display("FAIL b2b_mcount: got %0d want 9", mispredict_count); end
  endtask

  task automatic test_reset_mid();
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    n_checks++; if (branchpredict !== 1'b0) begin n_fail++; $display("FAIL rmid_bp: got %0b want 0", branchpredict); end
    n_checks++; if (pcbranch !== 32'h0) begin n_fail++; $display("FAIL rmid_pcbranch: got %0h want 0", pcbranch); end
    n_checks++; if (branch_count !== 32'd0) begin n_fail++; $display("FAIL rmid_bcount: got %0d want 0", branch_count); end
    n_checks++; if (mispredict_count !== 32'd0) begin n_fail++; $display("FAIL rmid_mcount: got %0d want 0", mispredict_count); end
    tick();
    reset = 1'b0;
    tick();
    n_checks++; if (branchpredict !== 1'b0) begin n_fail++; $display("FAIL rmid_after_bp: got %0b want 0", branchpredict); end
  endtask

  initial begin
    test_reset();
    test_train_taken();
    test_not_taken();
    test_alias_saturate();
    test_target_and_wrap();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
